// File: rtl/mii_pkg.sv
// Shared constants and types for the MII receive frame checker.
package mii_pkg;

  localparam int unsigned MII_DATA_WIDTH = 64;
  localparam logic [7:0]  MII_IDLE_CODE  = 8'h07;
  localparam logic [7:0]  MII_START_CODE = 8'hFB;
  localparam logic [7:0]  MII_EOF_CODE   = 8'hFD;
  localparam logic [63:0] MII_DATA_PATTERN = {8{8'hAA}};

  typedef enum logic [2:0] {
    W_IDLE,
    W_START,
    W_DATA,
    W_EOF,
    W_BAD
  } word_class_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_DROP
  } rx_state_t;

  typedef enum logic [2:0] {
    ERR_NONE           = 3'd0,
    ERR_DATA_OUTSIDE   = 3'd1,
    ERR_ORPHAN_EOF     = 3'd2,
    ERR_BAD_WORD       = 3'd3,
    ERR_OVERSIZE       = 3'd4,
    ERR_EMPTY          = 3'd5,
    ERR_START_IN_FRAME = 3'd6,
    ERR_TRUNCATED      = 3'd7
  } err_code_t;

endpackage

// File: rtl/mii_word_classifier.sv
// Combinational classification of one MII word into IDLE/START/DATA/EOF/BAD.
module mii_word_classifier
  import mii_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MII_DATA_WIDTH,
  parameter logic [7:0]  IDLE_CODE  = MII_IDLE_CODE,
  parameter logic [7:0]  START_CODE = MII_START_CODE,
  parameter logic [7:0]  EOF_CODE   = MII_EOF_CODE
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  ctrl,
  output word_class_t           word_class_c
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  logic [NBYTES-1:0] is_idle;

  always_comb begin
    for (int i = 0; i < int'(NBYTES); i++) begin
      is_idle[i] = (data[8*i +: 8] == IDLE_CODE);
    end
  end

  // START carries its code in the lowest byte, EOF in the highest byte
  always_comb begin
    word_class_c = W_BAD;
    if (!ctrl) begin
      word_class_c = W_DATA;
    end else if (&is_idle) begin
      word_class_c = W_IDLE;
    end else if ((data[7:0] == START_CODE) && (&is_idle[NBYTES-1:1])) begin
      word_class_c = W_START;
    end else if ((data[DATA_WIDTH-1 -: 8] == EOF_CODE) && (&is_idle[NBYTES-2:0])) begin
      word_class_c = W_EOF;
    end
  end

endmodule

// File: rtl/mii_rx_checker.sv
// Receive-side MII frame checker: delineates frames, forwards payload with
// sof/eof markers and counts protocol errors. Optional RX_CHECK_PAYLOAD_EN
// compares every payload word against DATA_PATTERN.
module mii_rx_checker
  import mii_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = MII_DATA_WIDTH,
  parameter logic [7:0]  IDLE_CODE      = MII_IDLE_CODE,
  parameter logic [7:0]  START_CODE     = MII_START_CODE,
  parameter logic [7:0]  EOF_CODE       = MII_EOF_CODE,
  parameter int unsigned MAX_DATA_WORDS = 16,
  parameter int unsigned CNT_WIDTH      = 16
`ifdef RX_CHECK_PAYLOAD_EN
  , parameter logic [DATA_WIDTH-1:0] DATA_PATTERN = {(DATA_WIDTH/8){8'hAA}}
`endif
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_ctrl,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic                  o_frame_ok,
  output logic                  o_frame_err,
  output logic [2:0]            o_err_code,
  output logic [CNT_WIDTH-1:0]  o_frame_cnt,
  output logic [CNT_WIDTH-1:0]  o_err_cnt
);

  localparam int unsigned CW = $clog2(MAX_DATA_WORDS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DATA_WORDS);

  word_class_t wclass_c;

  mii_word_classifier #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDLE_CODE  (IDLE_CODE),
    .START_CODE (START_CODE),
    .EOF_CODE   (EOF_CODE)
  ) u_classifier (
    .data         (i_rx_data),
    .ctrl         (i_rx_ctrl),
    .word_class_c (wclass_c)
  );

  rx_state_t             state_q, state_n;
  logic [CW-1:0]         count_q, count_n;
  logic [DATA_WIDTH-1:0] hold_q, hold_n;

  logic [DATA_WIDTH-1:0] data_n;
  logic                  valid_n, sof_n, eof_n, ok_n, err_n;
  err_code_t             code_n;
  logic [CNT_WIDTH-1:0]  frame_cnt_n, err_cnt_n;
  logic                  frame_bad_c;

`ifdef RX_CHECK_PAYLOAD_EN
  // Per-frame payload mismatch flag, cleared by any START
  logic flag_q, flag_n;
  logic mismatch_c;

  assign mismatch_c  = (i_rx_data != DATA_PATTERN);
  assign frame_bad_c = flag_q;

  always_comb begin
    flag_n = flag_q;
    if (wclass_c == W_START) begin
      flag_n = 1'b0;
    end else if ((state_q == S_DATA) && (wclass_c == W_DATA) &&
                 (count_q != MAX_CNT) && mismatch_c) begin
      flag_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) flag_q <= 1'b0;
    else       flag_q <= flag_n;
  end
`else
  assign frame_bad_c = 1'b0;
`endif

  // Next-state, hold register and output decode; hold is non-empty iff count > 0
  always_comb begin
    state_n = state_q;
    count_n = count_q;
    hold_n  = hold_q;
    data_n  = o_data;
    valid_n = 1'b0;
    sof_n   = 1'b0;
    eof_n   = 1'b0;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    code_n  = err_code_t'(o_err_code);

    unique case (state_q)
      S_IDLE: begin
        unique case (wclass_c)
          W_START: begin
            state_n = S_DATA;
            count_n = '0;
          end
          W_DATA: begin err_n = 1'b1; code_n = ERR_DATA_OUTSIDE; end
          W_EOF:  begin err_n = 1'b1; code_n = ERR_ORPHAN_EOF;   end
          W_BAD:  begin err_n = 1'b1; code_n = ERR_BAD_WORD;     end
          default: ;
        endcase
      end

      S_DATA: begin
        unique case (wclass_c)
          W_DATA: begin
            if (count_q == MAX_CNT) begin
              err_n   = 1'b1;
              code_n  = ERR_OVERSIZE;
              state_n = S_DROP;
              count_n = '0;
            end else begin
              if (count_q != '0) begin
                valid_n = 1'b1;
                data_n  = hold_q;
                sof_n   = (count_q == CW'(1));
              end
              hold_n  = i_rx_data;
              count_n = count_q + CW'(1);
            end
          end
          W_EOF: begin
            if (count_q == '0) begin
              err_n  = 1'b1;
              code_n = ERR_EMPTY;
            end else begin
              valid_n = 1'b1;
              data_n  = hold_q;
              sof_n   = (count_q == CW'(1));
              eof_n   = 1'b1;
              if (frame_bad_c) begin
                err_n  = 1'b1;
                code_n = ERR_TRUNCATED;
              end else begin
                ok_n = 1'b1;
              end
            end
            state_n = S_IDLE;
            count_n = '0;
          end
          W_START: begin
            err_n   = 1'b1;
            code_n  = ERR_START_IN_FRAME;
            count_n = '0;
          end
          W_IDLE: begin
            err_n   = 1'b1;
            code_n  = ERR_TRUNCATED;
            state_n = S_IDLE;
            count_n = '0;
          end
          default: begin
            err_n   = 1'b1;
            code_n  = ERR_BAD_WORD;
            state_n = S_IDLE;
            count_n = '0;
          end
        endcase
      end

      S_DROP: begin
        unique case (wclass_c)
          W_EOF, W_IDLE: state_n = S_IDLE;
          W_START: begin
            state_n = S_DATA;
            count_n = '0;
          end
          default: ;
        endcase
      end

      default: state_n = S_IDLE;
    endcase

    frame_cnt_n = o_frame_cnt;
    if (ok_n && (o_frame_cnt != '1)) frame_cnt_n = o_frame_cnt + CNT_WIDTH'(1);
    err_cnt_n = o_err_cnt;
    if (err_n && (o_err_cnt != '1)) err_cnt_n = o_err_cnt + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      hold_q      <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_code  <= 3'd0;
      o_frame_cnt <= '0;
      o_err_cnt   <= '0;
    end else begin
      state_q     <= state_n;
      count_q     <= count_n;
      hold_q      <= hold_n;
      o_data      <= data_n;
      o_valid     <= valid_n;
      o_sof       <= sof_n;
      o_eof       <= eof_n;
      o_frame_ok  <= ok_n;
      o_frame_err <= err_n;
      o_err_code  <= code_n;
      o_frame_cnt <= frame_cnt_n;
      o_err_cnt   <= err_cnt_n;
    end
  end

endmodule

// File: tb/tb_mii_rx_checker.sv
// Directed self-checking bench for mii_rx_checker (16-bit and 2-bit counter instances).
module tb_mii_rx_checker;

  localparam logic [63:0] IDLE_W  = 64'h0707_0707_0707_0707;
  localparam logic [63:0] START_W = 64'h0707_0707_0707_07FB;
  localparam logic [63:0] EOF_W   = 64'hFD07_0707_0707_0707;
  localparam logic [63:0] PAT_W   = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] BAD_W   = 64'h0707_0707_0707_07FE;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] rx_data;
  logic        rx_ctrl;

  logic [63:0] data;
  logic        valid, sof, eof, ok, ferr;
  logic [2:0]  code;
  logic [15:0] fcnt, ecnt;

  logic [63:0] s_data;
  logic        s_valid, s_sof, s_eof, s_ok, s_ferr;
  logic [2:0]  s_code;
  logic [1:0]  s_fcnt, s_ecnt;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int exp_errs = 0;

  always #5 clk = ~clk;

  mii_rx_checker dut (
    .clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_ctrl(rx_ctrl),
    .o_data(data), .o_valid(valid), .o_sof(sof), .o_eof(eof),
    .o_frame_ok(ok), .o_frame_err(ferr), .o_err_code(code),
    .o_frame_cnt(fcnt), .o_err_cnt(ecnt)
  );

  mii_rx_checker #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_ctrl(rx_ctrl),
    .o_data(s_data), .o_valid(s_valid), .o_sof(s_sof), .o_eof(s_eof),
    .o_frame_ok(s_ok), .o_frame_err(s_ferr), .o_err_code(s_code),
    .o_frame_cnt(s_fcnt), .o_err_cnt(s_ecnt)
  );

  // Present one word for one edge; outputs are observed 1 time unit after that edge
  task automatic send(input logic [63:0] d, input logic c);
    @(negedge clk);
    rx_data = d;
    rx_ctrl = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_data = '0; rx_ctrl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({data, valid, sof, eof, ok, ferr, code, fcnt, ecnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h v=%b sof=%b eof=%b ok=%b err=%b code=%0d fcnt=%0d ecnt=%0d, all zero required",
               data, valid, sof, eof, ok, ferr, code, fcnt, ecnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_errs++;
    checks++;
    if (ferr !== 1'b1 || code !== 3'd1 || ecnt !== 16'(exp_errs) || valid !== 1'b0) begin
      errors++;
      $display("FAIL first_word_err: err=%b code=%0d ecnt=%0d v=%b, required err=1 code=1 ecnt=%0d v=0",
               ferr, code, ecnt, valid, exp_errs);
    end
  endtask

  task automatic test_generator;
    for (int f = 0; f < 3; f++) begin
      send(IDLE_W, 1'b1);
      send(START_W, 1'b1);
      send(PAT_W, 1'b0);
      checks++;
      if (valid !== 1'b0 || ferr !== 1'b0) begin
        errors++;
        $display("FAIL gen_data_beat%0d: v=%b err=%b, required v=0 err=0", f, valid, ferr);
      end
      send(EOF_W, 1'b1);
      exp_frames++;
      checks++;
      if (valid !== 1'b1 || sof !== 1'b1 || eof !== 1'b1 || data !== PAT_W || ok !== 1'b1 || ferr !== 1'b0) begin
        errors++;
        $display("FAIL gen_eof_beat%0d: v=%b sof=%b eof=%b data=%h ok=%b err=%b, required 1 1 1 %h 1 0",
                 f, valid, sof, eof, data, ok, ferr, PAT_W);
      end
    end
    checks++;
    if (fcnt !== 16'd3 || ecnt !== 16'(exp_errs)) begin
      errors++;
      $display("FAIL gen_counters: fcnt=%0d ecnt=%0d, required 3 %0d", fcnt, ecnt, exp_errs);
    end
  endtask

  task automatic test_max_frame;
    int beats;
    beats = 0;
    send(START_W, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      send(64'(i), 1'b0);
      if (valid === 1'b1) begin
        beats++;
        checks++;
        if (data !== 64'(beats) || sof !== (beats == 1) || eof !== 1'b0 || ferr !== 1'b0) begin
          errors++;
          $display("FAIL max_beat%0d: data=%h sof=%b eof=%b err=%b, required %h %b 0 0",
                   beats, data, sof, eof, ferr, 64'(beats), beats == 1);
        end
      end
    end
    send(EOF_W, 1'b1);
    exp_frames++;
    checks++;
    if (valid !== 1'b1 || data !== 64'd16 || eof !== 1'b1 || sof !== 1'b0 || ok !== 1'b1 || beats != 15) begin
      errors++;
      $display("FAIL max_last: v=%b data=%h eof=%b sof=%b ok=%b prior_beats=%0d, required 1 10 1 0 1 15",
               valid, data, eof, sof, ok, beats);
    end
  endtask

  task automatic test_oversize;
    int beats;
    beats = 0;
    send(START_W, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      send(PAT_W, 1'b0);
      if (valid === 1'b1) beats++;
      if (eof === 1'b1) beats += 100;
    end
    send(PAT_W, 1'b0);
    exp_errs++;
    checks++;
    if (ferr !== 1'b1 || code !== 3'd4 || valid !== 1'b0 || beats != 15) begin
      errors++;
      $display("FAIL oversize_err: err=%b code=%0d v=%b beats=%0d, required 1 4 0 15", ferr, code, valid, beats);
    end
    send(PAT_W, 1'b0);
    send(EOF_W, 1'b1);
    checks++;
    if (valid !== 1'b0 || ok !== 1'b0 || ferr !== 1'b0 || fcnt !== 16'(exp_frames) || ecnt !== 16'(exp_errs)) begin
      errors++;
      $display("FAIL oversize_drop: v=%b ok=%b err=%b fcnt=%0d ecnt=%0d, required 0 0 0 %0d %0d",
               valid, ok, ferr, fcnt, ecnt, exp_frames, exp_errs);
    end
  endtask

  task automatic test_empty_orphan;
    send(START_W, 1'b1);
    send(EOF_W, 1'b1);
    exp_errs++;
    checks++;
    if (ferr !== 1'b1 || code !== 3'd5 || valid !== 1'b0 || ok !== 1'b0) begin
      errors++;
      $display("FAIL empty_frame: err=%b code=%0d v=%b ok=%b, required 1 5 0 0", ferr, code, valid, ok);
    end
    send(EOF_W, 1'b1);
    exp_errs++;
    checks++;
    if (ferr !== 1'b1 || code !== 3'd2) begin
      errors++;
      $display("FAIL orphan_eof: err=%b code=%0d, required 1 2", ferr, code);
    end
  endtask

  task automatic test_restart;
    send(START_W, 1'b1);
    send(64'h1111, 1'b0);
    send(START_W, 1'b1);
    exp_errs++;
    checks++;
    if (ferr !== 1'b1 || code !== 3'd6 || valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_err: err=%b code=%0d v=%b, required 1 6 0", ferr, code, valid);
    end
    send(64'h2222, 1'b0);
    send(EOF_W, 1'b1);
    exp_frames++;
    checks++;
    if (valid !== 1'b1 || data !== 64'h2222 || sof !== 1'b1 || eof !== 1'b1 || ok !== 1'b1 || ferr !== 1'b0) begin
      errors++;
      $display("FAIL restart_beat: v=%b data=%h sof=%b eof=%b ok=%b err=%b, required 1 2222 1 1 1 0",
               valid, data, sof, eof, ok, ferr);
    end
  endtask

  task automatic test_bad_truncated;
    send(START_W, 1'b1);
    send(PAT_W, 1'b0);
    send(BAD_W, 1'b1);
    exp_errs++;
    checks++;
    if (ferr !== 1'b1 || code !== 3'd3 || valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_word: err=%b code=%0d v=%b, required 1 3 0", ferr, code, valid);
    end
    send(PAT_W, 1'b0);
    exp_errs++;
    checks++;
    if (ferr !== 1'b1 || code !== 3'd1) begin
      errors++;
      $display("FAIL bad_back_to_idle: err=%b code=%0d, required 1 1", ferr, code);
    end
    send(START_W, 1'b1);
    send(PAT_W, 1'b0);
    send(IDLE_W, 1'b1);
    exp_errs++;
    checks++;
    if (ferr !== 1'b1 || code !== 3'd7 || valid !== 1'b0 || ok !== 1'b0) begin
      errors++;
      $display("FAIL truncated: err=%b code=%0d v=%b ok=%b, required 1 7 0 0", ferr, code, valid, ok);
    end
    send(IDLE_W, 1'b1);
    checks++;
    if (ferr !== 1'b0 || code !== 3'd7) begin
      errors++;
      $display("FAIL sticky_code: err=%b code=%0d, required 0 7", ferr, code);
    end
  endtask

  task automatic test_payload;
    logic exp_ok;
    send(START_W, 1'b1);
    send(64'h0, 1'b0);
    send(EOF_W, 1'b1);
`ifdef RX_CHECK_PAYLOAD_EN
    exp_ok = 1'b0;
    exp_errs++;
`else
    exp_ok = 1'b1;
    exp_frames++;
`endif
    checks++;
    if (valid !== 1'b1 || eof !== 1'b1 || data !== 64'h0 || ok !== exp_ok || ferr !== !exp_ok ||
        (!exp_ok && code !== 3'd7)) begin
      errors++;
      $display("FAIL payload_frame: v=%b eof=%b data=%h ok=%b err=%b code=%0d, required v=1 eof=1 data=0 ok=%b",
               valid, eof, data, ok, ferr, code, exp_ok);
    end
    checks++;
    if (fcnt !== 16'(exp_frames) || ecnt !== 16'(exp_errs)) begin
      errors++;
      $display("FAIL totals: fcnt=%0d ecnt=%0d, required %0d %0d", fcnt, ecnt, exp_frames, exp_errs);
    end
  endtask

  task automatic test_saturation;
    checks++;
    if (s_fcnt !== 2'b11 || s_ecnt !== 2'b11) begin
      errors++;
      $display("FAIL counter_saturate: fcnt=%0d ecnt=%0d, required 3 3", s_fcnt, s_ecnt);
    end
  endtask

  task automatic test_reset_mid_frame;
    send(START_W, 1'b1);
    send(64'h5, 1'b0);
    send(64'h6, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({valid, ok, ferr, code, fcnt, ecnt} !== '0 || data !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid: v=%b ok=%b err=%b code=%0d fcnt=%0d ecnt=%0d data=%h, all zero required",
               valid, ok, ferr, code, fcnt, ecnt, data);
    end
    @(negedge clk);
    rst = 1'b0;
    rx_data = IDLE_W;
    rx_ctrl = 1'b1;
    send(EOF_W, 1'b1);
    checks++;
    if (ferr !== 1'b1 || code !== 3'd2 || valid !== 1'b0 || ecnt !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_state: err=%b code=%0d v=%b ecnt=%0d, required 1 2 0 1", ferr, code, valid, ecnt);
    end
  endtask

  initial begin
    test_reset();
    test_generator();
    test_max_frame();
    test_oversize();
    test_empty_orphan();
    test_restart();
    test_bad_truncated();
    test_payload();
    test_saturation();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mii_rx_checker.md
# mii_rx_checker

Receive-side frame checker for the 64-bit, 1-bit-control MII word stream produced by the team's frame generator. It classifies each incoming word as IDLE, START, DATA or EOF, delineates frames, and forwards payload words with start/end markers. It detects and counts protocol errors. It sits at the receive end of the loopback path and drives the payload sink and the error/statistics monitor.

## Interface
- DATA_WIDTH, 64, word width in bits; fixed at 8 bytes.
- IDLE_CODE, 8'h07, idle byte.
- START_CODE, 8'hFB, start byte.
- EOF_CODE, 8'hFD, terminate byte.
- DATA_PATTERN, {8{8'hAA}}, expected payload word (used only with the payload check).
- MAX_DATA_WORDS, 16, maximum DATA words per frame (≥1).
- CNT_WIDTH, 16, statistics counter width.
- clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rx_data  in  DATA_WIDTH  received word.
- i_rx_ctrl  in  1  1 = control word, 0 = all-data word.
- o_data  out  DATA_WIDTH  forwarded payload word.
- o_valid  out  1  o_data valid this cycle.
- o_sof  out  1  first payload word of frame (qualified by o_valid).
- o_eof  out  1  last payload word of frame (qualified by o_valid).
- o_frame_ok  out  1  one-cycle pulse: frame completed cleanly.
- o_frame_err  out  1  one-cycle pulse: error detected; any partially delivered frame is void.
- o_err_code  out  3  code of the most recent error; sticky until the next error.
- o_frame_cnt  out  CNT_WIDTH  good frames, saturating.
- o_err_cnt  out  CNT_WIDTH  errors, saturating.

## Operation
- Word classes, evaluated on the current input:
  - IDLE_W: ctrl=1 and all bytes = IDLE_CODE.
  - START_W: ctrl=1, byte0 = START_CODE, bytes 7:1 = IDLE_CODE.
  - EOF_W: ctrl=1, byte7 = EOF_CODE, bytes 6:0 = IDLE_CODE.
  - DATA_W: ctrl=0.
  - BAD_W: any other ctrl=1 word.
- Error codes:
  - 1: DATA outside a frame.
  - 2: orphan EOF.
  - 3: BAD_W.
  - 4: oversize.
  - 5: empty frame.
  - 6: START inside a frame.
  - 7: truncated frame (IDLE inside a frame).
  - 0: none since reset. Payload mismatch also reports 7 (see Configuration).
- S_IDLE:
  - IDLE_W → stay.
  - START_W → S_DATA, word count := 0, hold register empty.
  - DATA_W → err 1.
  - EOF_W → err 2.
  - BAD_W → err 3.
  - All three errors stay in S_IDLE.
- S_DATA:
  - DATA_W: if count = MAX_DATA_WORDS, raise err 4, drop the held word and go to S_DROP. Otherwise the held word (if any) goes to the output with o_valid, and the new word goes into the hold register; count++.
  - EOF_W: if count = 0, raise err 5. Otherwise emit the held word with o_eof=1 and pulse o_frame_ok. Either way → S_IDLE.
  - START_W: raise err 6, drop the held word, restart the frame (stay in S_DATA, count := 0).
  - IDLE_W / BAD_W: raise err 7 / err 3, drop the held word, go to S_IDLE.
- S_DROP:
  - EOF_W or IDLE_W → S_IDLE, no further error.
  - START_W → S_DATA, new frame.
  - All other words are ignored.
- o_sof is set on the first word emitted after START.
- A single-word frame emits one word with o_sof = o_eof = 1.
- o_frame_ok and o_frame_err are never high in the same cycle.
- Counters saturate at all-ones; o_err_cnt increments once per o_frame_err pulse.

## Timing
- The word sampled at edge t is held. It is emitted, registered, after edge t+1, when the next DATA_W or EOF_W is sampled.
- For a continuous frame, latency from input to o_data is 2 edges.
- o_frame_ok / o_frame_err / o_err_code / counters update on the edge that samples the deciding word.
- o_frame_ok is coincident with the o_eof beat.
- Reset: state S_IDLE, hold register empty, count 0. All outputs 0, including o_data, o_err_code and both counters.
- Reset mid-frame discards the held word; no pulse is generated.

## Configuration
- RX_CHECK_PAYLOAD_EN defined: every DATA_W is compared with DATA_PATTERN, and a mismatch sets a per-frame flag.
  - At a flagged frame's EOF: o_frame_err pulses with code 7, and o_frame_ok is suppressed. The frame is still forwarded with o_eof.
  - The flag clears on START and on reset.
- Not defined: no comparison, and the flag logic is absent.

## Structure
- Package mii_pkg:
  - IDLE/START/EOF code constants.
  - Word-class enum.
  - rx_state_t (S_IDLE, S_DATA, S_DROP).
  - err_code_t enum.
- Sub-module mii_word_classifier: combinational; inputs data/ctrl, outputs the word class.

## Test plan
- Generator loop (IDLE, START, DATA 64'hAAAA_AAAA_AAAA_AAAA, EOF) from a common reset. First sampled word is 0 with ctrl=0 → err 1, o_err_cnt=1. Then each 4-cycle frame gives one beat of 64'hAA..AA with sof=eof=1 and an o_frame_ok pulse; o_frame_cnt=3 after 3 frames.
- START, 16 DATA, EOF → 16 beats with sof on beat 1 and eof on beat 16, frame_ok. START, 17 DATA → err 4 on the 17th word, no eof beat, then S_DROP until EOF.
- START then EOF → err 5, no o_valid. EOF in S_IDLE → err 2.
- START, DATA, START, DATA, EOF → err 6 on the second START; one beat (sof=eof=1) and frame_ok from the second frame only.
- START, DATA, ctrl=1 word 64'h0707_0707_0707_07FE → err 3, state S_IDLE. Counter preset near all-ones saturates at 16'hFFFF.
- Only with RX_CHECK_PAYLOAD_EN: START, DATA 64'h0, EOF → beat forwarded with eof, err 7, no frame_ok.
